mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter for the 5-stage RISC-V pipeline. It shares one unified external memory bus between the IF-stage instruction fetch and the MEM-stage load/store. It sequences each access through a valid/ready bus handshake and returns data with a one-cycle ready pulse. The hazard unit builds its stall terms from this pulse: fetch stall = ifreq & ~ifready, memory stall = dreq & ~dready.

## Interface
- TIMEOUT, 255: max wait cycles for bus_ready before abort; only used with ARB_TIMEOUT_EN.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ifreq  in  1  fetch request; held until ifready.
- ifaddr  in  32  fetch address (pcF).
- ifready  out  1  one-cycle pulse: ifrdata valid.
- ifrdata  out  32  fetched instruction; holds until next fetch completes.
- dreq  in  1  load/store request; held until dready.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  32  data address (aluresultM).
- dwdata  in  32  store data (writedataM).
- dbe  in  4  store byte enables.
- dready  out  1  one-cycle pulse: access done, drdata valid for loads.
- drdata  out  32  load data; holds until next data access completes.
- bus_valid  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables; 4'b1111 for fetches and loads.
- bus_ready  in  1  slave completion, sampled on rising edge.
- bus_rdata  in  32  read data, valid when bus_ready = 1.
- buserr  out  1  sticky timeout flag.

## Operation
- States:
  - IDLE: no transaction in progress.
  - IACC / DACC: fetch / data transaction on the bus.
  - IDONE / DDONE: response cycle for fetch / data.
- IDLE:
  - dreq → DACC. Data has priority because it belongs to the older instruction.
  - Else ifreq → IACC.
  - Else stay in IDLE.
- On entering IACC/DACC, register the request into bus_addr, bus_we, bus_wdata and bus_be.
  - The bus is driven only from these registers.
  - Changing ifaddr/daddr mid-transaction (e.g. a redirect on pcsrcE) does not affect the bus.
- In IACC/DACC:
  - bus_valid = 1 and all bus outputs are held stable.
  - On an edge with bus_ready = 1: capture bus_rdata into ifrdata (IACC) or drdata (DACC loads), then go to IDONE/DDONE.
  - Stores leave drdata unchanged.
- IDONE:
  - ifready = 1; bus_valid = 0.
  - Next state: DACC if dreq, else IDLE.
  - The ifready pulse is issued even if ifreq dropped; the fetch side discards it.
- DDONE:
  - dready = 1.
  - Next state: IACC if ifreq, else IDLE.
  - This guarantees one fetch between consecutive data accesses (no fetch starvation).
- ifready and dready are never high in the same cycle. At most one bus transaction is outstanding.
- Reset at any time:
  - Next state IDLE; all outputs return to reset values at the reset edge.
  - Any in-flight bus transaction is abandoned; the slave is reset by the same reset.
- Reset values: bus_valid 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, ifready 0, dready 0, ifrdata 0, drdata 0, buserr 0; state IDLE.

## Timing
- Minimum latency from request to ready pulse is 2 cycles:
  - cycle 0: request sampled in IDLE;
  - cycle 1: in IACC/DACC, bus_ready = 1;
  - cycle 2: ifready/dready pulse.
- Each bus wait cycle adds exactly one cycle.
- dreq and ifreq both asserted in IDLE at cycle 0: dready at cycle 2, fetch bus_valid at cycle 3, ifready at cycle 4 (zero-wait slave).
- Back-to-back fetches with a zero-wait slave give one ifready every 3 cycles: the DONE → IDLE → ACC sequence.
- bus_valid is never asserted in IDLE or DONE states.
- No combinational path from bus_ready/bus_rdata to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A wait counter, $clog2(TIMEOUT+1) bits wide, clears on entry to IACC/DACC and increments each cycle bus_ready = 0.
  - When it equals TIMEOUT with bus_ready = 0: abort the transaction.
    - bus_valid drops on the next edge; go to IDONE/DDONE.
    - ifrdata loads 32'h00000013 (NOP); drdata loads 0 for loads.
    - Set buserr, which stays set until reset.
  - bus_ready in the same cycle as the count reaching TIMEOUT counts as success, not a timeout.
- ARB_TIMEOUT_EN undefined:
  - No counter; the arbiter waits indefinitely for bus_ready.
  - buserr is tied to 0; TIMEOUT is ignored.

## Test plan
- Reset/single fetch: reset for 2 cycles, then ifreq with ifaddr=0x00000010 and zero-wait slave returning 0x00500093 → bus_addr=0x10, bus_be=4'hF, ifready pulse 2 cycles after request, ifrdata=0x00500093 held afterwards.
- Store with waits: dreq, dwe=1, daddr=0x100, dwdata=0xDEADBEEF, dbe=4'b0011, bus_ready after 3 wait cycles → bus outputs stable for all 4 valid cycles, dready 5 cycles after request, drdata unchanged.
- Simultaneous requests: ifreq and dreq together in IDLE (load 0x200 returns 0x12345678) → data served first (dready at cycle 2, drdata=0x12345678), ifready at cycle 4; never both ready in one cycle.
- No starvation: dreq held continuously with a new load each dready, and ifreq asserted → ifready occurs between every pair of dready pulses.
- Redirect mid-fetch: ifaddr changes 0x40→0x80 during IACC with 2 wait cycles → bus_addr stays 0x40, ifready still pulses.
- Reset mid-transaction and timeout:
  - reset asserted in DACC → next cycle bus_valid=0, state IDLE, all outputs at reset values.
  - With ARB_TIMEOUT_EN and TIMEOUT=4, slave never ready → ifready after 4 wait cycles, ifrdata=0x00000013, buserr=1 until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one valid/ready bus between IF fetch and MEM load/store.
// Optional feature macro ARB_TIMEOUT_EN adds a bus wait timeout with a sticky buserr flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifreq,
    input  logic [31:0] ifaddr,
    output logic        ifready,
    output logic [31:0] ifrdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbe,
    output logic        dready,
    output logic [31:0] drdata,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        buserr
);

    localparam logic [31:0] NopInsn = 32'h0000_0013;

    typedef enum logic [2:0] {StIdle, StIacc, StDacc, StIdone, StDdone} state_e;

    state_e      state_q, state_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] ifrdata_q, ifrdata_d;
    logic [31:0] drdata_q, drdata_d;

    logic load_i, load_d;
    logic cap_i, cap_d;
    logic abort_i, abort_d;
    logic in_acc;
    logic timeout_hit;

    assign in_acc = (state_q == StIacc) || (state_q == StDacc);

    always_comb begin
        state_d = state_q;
        load_i  = 1'b0;
        load_d  = 1'b0;
        cap_i   = 1'b0;
        cap_d   = 1'b0;
        abort_i = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Data wins: it belongs to the older instruction in the pipe.
                if (dreq) begin
                    state_d = StDacc;
                    load_d  = 1'b1;
                end else if (ifreq) begin
                    state_d = StIacc;
                    load_i  = 1'b1;
                end
            end
            StIacc: begin
                if (bus_ready) begin
                    state_d = StIdone;
                    cap_i   = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StIdone;
                    abort_i = 1'b1;
                end
            end
            StDacc: begin
                if (bus_ready) begin
                    state_d = StDdone;
                    cap_d   = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StDdone;
                    abort_d = 1'b1;
                end
            end
            StIdone: begin
                if (dreq) begin
                    state_d = StDacc;
                    load_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StDdone: begin
                // Fetch goes next so a stream of data accesses cannot starve IF.
                if (ifreq) begin
                    state_d = StIacc;
                    load_i  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if (load_d) begin
            bus_we_d    = dwe;
            bus_addr_d  = daddr;
            bus_wdata_d = dwdata;
            bus_be_d    = dwe ? dbe : 4'hF;
        end else if (load_i) begin
            bus_we_d    = 1'b0;
            bus_addr_d  = ifaddr;
            bus_wdata_d = 32'h0;
            bus_be_d    = 4'hF;
        end
    end

    always_comb begin
        ifrdata_d = ifrdata_q;
        drdata_d  = drdata_q;
        if (cap_i) begin
            ifrdata_d = bus_rdata;
        end else if (abort_i) begin
            ifrdata_d = NopInsn;
        end
        if (cap_d && !bus_we_q) begin
            drdata_d = bus_rdata;
        end else if (abort_d && !bus_we_q) begin
            drdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            ifrdata_q   <= 32'h0;
            drdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ifrdata_q   <= ifrdata_d;
            drdata_q    <= drdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            buserr_q, buserr_d;

    // Abort on the TIMEOUT-th consecutive cycle without bus_ready.
    assign timeout_hit = ((32'(wait_cnt_q) + 32'd1) >= TIMEOUT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (load_i || load_d) begin
            wait_cnt_d = '0;
        end else if (in_acc && !bus_ready) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
        buserr_d = buserr_q | abort_i | abort_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            buserr_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            buserr_q   <= buserr_d;
        end
    end

    assign buserr = buserr_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign buserr         = 1'b0;
`endif

    assign bus_valid = in_acc;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign ifready   = (state_q == StIdone);
    assign dready    = (state_q == StDdone);
    assign ifrdata   = ifrdata_q;
    assign drdata    = drdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random-latency slave model plus per-feature scenarios.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned TbTimeout = 4;

    logic        clk;
    logic        reset;
    logic        ifreq;
    logic [31:0] ifaddr;
    logic        ifready;
    logic [31:0] ifrdata;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        dready;
    logic [31:0] drdata;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        buserr;

    int n_checks;
    int n_errors;
    int slave_wait;    // wait cycles for the next transaction; -1 picks 0..3 at random
    bit mon_en;
    bit mon_pv;
    logic [68:0] mon_pb;

    logic [31:0] exp_ifrdata;
    logic [31:0] exp_drdata;
    logic [31:0] mem [logic [31:0]];

    mem_arbiter #(.TIMEOUT(TbTimeout)) dut (
        .clk       (clk),
        .reset     (reset),
        .ifreq     (ifreq),
        .ifaddr    (ifaddr),
        .ifready   (ifready),
        .ifrdata   (ifrdata),
        .dreq      (dreq),
        .dwe       (dwe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dbe       (dbe),
        .dready    (dready),
        .drdata    (drdata),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .buserr    (buserr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0F1E};
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: data only while ready, garbage otherwise.
    initial begin
        bit in_txn;
        int wl;
        in_txn    = 1'b0;
        wl        = 0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !bus_valid) begin
                in_txn    = 1'b0;
                bus_ready = 1'b0;
                bus_rdata = $urandom;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wl = (slave_wait < 0) ? int'($urandom_range(0, 3)) : slave_wait;
                end
                if (wl == 0) begin
                    bus_ready = 1'b1;
                    bus_rdata = mem_rd(bus_addr);
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                    wl--;
                end
            end
        end
    end

    // Protocol invariants checked every cycle once out of reset.
    initial begin
        mon_pv = 1'b0;
        mon_pb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                n_checks++;
                if (ifready && dready) begin
                    n_errors++;
                    $display("FAIL both_ready at %0t: ifready=%b dready=%b want not both", $time,
                             ifready, dready);
                end
                n_checks++;
                if (bus_valid && (ifready || dready)) begin
                    n_errors++;
                    $display("FAIL valid_in_done at %0t: bus_valid=%b want 0", $time, bus_valid);
                end
                if (bus_valid && mon_pv) begin
                    n_checks++;
                    if ({bus_we, bus_addr, bus_wdata, bus_be} !== mon_pb) begin
                        n_errors++;
                        $display("FAIL bus_stable at %0t: got %h want %h", $time,
                                 {bus_we, bus_addr, bus_wdata, bus_be}, mon_pb);
                    end
                end
`ifndef ARB_TIMEOUT_EN
                n_checks++;
                if (buserr !== 1'b0) begin
                    n_errors++;
                    $display("FAIL buserr_tied at %0t: got %b want 0", $time, buserr);
                end
`endif
                mon_pv = bus_valid;
                mon_pb = {bus_we, bus_addr, bus_wdata, bus_be};
            end
        end
    end

    // Drives one request from IDLE until its ready pulse and returns to IDLE; measures only.
    task automatic run_single(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input int waits,
                              input int redir_at, input logic [31:0] redir_addr,
                              output int lat, output int vcyc, output bit stable,
                              output bit other);
        int c;
        lat = -1;
        vcyc = 0;
        stable = 1'b1;
        other = 1'b0;
        c = 0;
        slave_wait = waits;
        if (is_d) begin
            dreq = 1'b1; dwe = we; daddr = addr; dwdata = wdata; dbe = be;
        end else begin
            ifreq = 1'b1; ifaddr = addr;
        end
        while (c < 40 && lat < 0) begin
            tick();
            c++;
            if (bus_valid) begin
                vcyc++;
                if (bus_addr !== addr || bus_we !== we ||
                    bus_be !== ((is_d && we) ? be : 4'hF) || (we && bus_wdata !== wdata))
                    stable = 1'b0;
            end
            if (!is_d && c == redir_at) ifaddr = redir_addr;
            if (is_d ? dready : ifready) lat = c;
            if (is_d ? ifready : dready) other = 1'b1;
        end
        dreq = 1'b0;
        ifreq = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_be, ifready, dready, ifrdata, drdata,
             buserr} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: got %h want 0", {bus_valid, bus_we, bus_addr,
                     bus_wdata, bus_be, ifready, dready, ifrdata, drdata, buserr});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({bus_valid, ifready, dready} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b want 000", {bus_valid, ifready, dready});
        end
        exp_ifrdata = 32'h0;
        exp_drdata = 32'h0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_fetch();
        int lat, vc;
        bit st, ot;
        mem[32'h10] = 32'h0050_0093;
        run_single(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 32'h0, lat, vc, st, ot);
        exp_ifrdata = 32'h0050_0093;
        n_checks++;
        if (lat !== 2) begin
            n_errors++; $display("FAIL fetch_latency: got %0d want 2", lat);
        end
        n_checks++;
        if (!st || vc !== 1) begin
            n_errors++; $display("FAIL fetch_bus: stable=%b valid_cycles=%0d want 1/1", st, vc);
        end
        tick();
        n_checks++;
        if (ifrdata !== exp_ifrdata || ifready !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_hold: ifrdata=%h ifready=%b want %h/0", ifrdata, ifready,
                     exp_ifrdata);
        end
    endtask

    task automatic test_store_waits();
        int lat, vc;
        bit st, ot;
        run_single(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 3, 0, 32'h0, lat, vc, st, ot);
        n_checks++;
        if (lat !== 5) begin
            n_errors++; $display("FAIL store_latency: got %0d want 5", lat);
        end
        n_checks++;
        if (!st || vc !== 4) begin
            n_errors++; $display("FAIL store_bus: stable=%b valid_cycles=%0d want 1/4", st, vc);
        end
        n_checks++;
        if (drdata !== exp_drdata) begin
            n_errors++; $display("FAIL store_drdata: got %h want %h", drdata, exp_drdata);
        end
    endtask

    task automatic test_random_access();
        for (int i = 0; i < 8; i++) begin
            bit isd, we, st, ot;
            logic [31:0] a, wd;
            logic [3:0] be;
            int w, lat, vc;
            isd = 1'($urandom_range(0, 1));
            we = isd ? 1'($urandom_range(0, 1)) : 1'b0;
            a = rnd_addr();
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            w = int'($urandom_range(0, 4));
            run_single(isd, we, a, wd, be, w, 0, 32'h0, lat, vc, st, ot);
            if (!isd) exp_ifrdata = mem_rd(a);
            else if (!we) exp_drdata = mem_rd(a);
            n_checks++;
            if (lat !== 2 + w || vc !== 1 + w) begin
                n_errors++;
                $display("FAIL rand_timing[%0d]: lat=%0d valid=%0d want %0d/%0d", i, lat, vc,
                         2 + w, 1 + w);
            end
            n_checks++;
            if (!st || ot) begin
                n_errors++;
                $display("FAIL rand_bus[%0d]: stable=%b other_ready=%b want 1/0", i, st, ot);
            end
            n_checks++;
            if (ifrdata !== exp_ifrdata || drdata !== exp_drdata) begin
                n_errors++;
                $display("FAIL rand_data[%0d]: if=%h d=%h want %h/%h", i, ifrdata, drdata,
                         exp_ifrdata, exp_drdata);
            end
        end
    endtask

    task automatic test_simultaneous();
        int d_at, i_at, iv_at, c;
        logic [31:0] fa;
        d_at = -1; i_at = -1; iv_at = -1; c = 0;
        fa = rnd_addr();
        mem[32'h200] = 32'h1234_5678;
        slave_wait = 0;
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h200; ifreq = 1'b1; ifaddr = fa;
        while (c < 20 && (d_at < 0 || i_at < 0)) begin
            tick();
            c++;
            if (bus_valid && d_at > 0 && iv_at < 0) iv_at = c;
            if (dready) begin d_at = c; dreq = 1'b0; end
            if (ifready) begin i_at = c; ifreq = 1'b0; end
        end
        dreq = 1'b0;
        ifreq = 1'b0;
        tick();
        exp_drdata = 32'h1234_5678;
        exp_ifrdata = mem_rd(fa);
        n_checks++;
        if (d_at !== 2 || iv_at !== 3 || i_at !== 4) begin
            n_errors++;
            $display("FAIL simul_order: dready@%0d fetch_valid@%0d ifready@%0d want 2/3/4",
                     d_at, iv_at, i_at);
        end
        n_checks++;
        if (drdata !== exp_drdata || ifrdata !== exp_ifrdata) begin
            n_errors++;
            $display("FAIL simul_data: d=%h if=%h want %h/%h", drdata, ifrdata, exp_drdata,
                     exp_ifrdata);
        end
    endtask

    task automatic test_back_to_back();
        int t[4];
        int n, c;
        logic [31:0] fa;
        for (int k = 0; k < 4; k++) t[k] = -100;
        n = 0; c = 0;
        slave_wait = 0;
        fa = rnd_addr();
        ifreq = 1'b1; ifaddr = fa;
        while (c < 40 && n < 4) begin
            tick();
            c++;
            if (ifready) begin
                t[n] = c;
                n++;
                exp_ifrdata = mem_rd(fa);
                n_checks++;
                if (ifrdata !== exp_ifrdata) begin
                    n_errors++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", n, ifrdata, exp_ifrdata);
                end
                fa = rnd_addr();
                ifaddr = fa;
            end
        end
        ifreq = 1'b0;
        tick();
        n_checks++;
        if (n !== 4 || t[0] !== 2) begin
            n_errors++; $display("FAIL b2b_first: count=%0d first@%0d want 4/2", n, t[0]);
        end
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (t[k] - t[k-1] !== 3) begin
                n_errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d want 3", k, t[k] - t[k-1]);
            end
        end
    endtask

    task automatic test_redirect();
        int lat, vc;
        bit st, ot;
        mem[32'h40] = $urandom;
        run_single(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1, 32'h80, lat, vc, st, ot);
        exp_ifrdata = mem_rd(32'h40);
        n_checks++;
        if (lat !== 4 || !st || vc !== 3) begin
            n_errors++;
            $display("FAIL redirect_bus: lat=%0d stable=%b valid=%0d want 4/1/3", lat, st, vc);
        end
        n_checks++;
        if (ifrdata !== exp_ifrdata) begin
            n_errors++; $display("FAIL redirect_data: got %h want %h", ifrdata, exp_ifrdata);
        end
    endtask

    task automatic test_no_starvation();
        int nd, ni, c;
        logic [31:0] fa, da;
        nd = 0; ni = 0; c = 0;
        slave_wait = -1;
        fa = rnd_addr();
        da = rnd_addr();
        dreq = 1'b1; dwe = 1'b0; daddr = da; ifreq = 1'b1; ifaddr = fa;
        while (c < 300 && nd < 8) begin
            tick();
            c++;
            if (dready) begin
                nd++;
                exp_drdata = mem_rd(da);
                n_checks++;
                if (drdata !== exp_drdata) begin
                    n_errors++;
                    $display("FAIL starve_ddata[%0d]: got %h want %h", nd, drdata, exp_drdata);
                end
                if (nd >= 2) begin
                    n_checks++;
                    if (ni !== 1) begin
                        n_errors++;
                        $display("FAIL starve_fetches[%0d]: got %0d want 1", nd, ni);
                    end
                end
                ni = 0;
                da = rnd_addr();
                daddr = da;
            end
            if (ifready) begin
                ni++;
                exp_ifrdata = mem_rd(fa);
                n_checks++;
                if (ifrdata !== exp_ifrdata) begin
                    n_errors++;
                    $display("FAIL starve_idata: got %h want %h", ifrdata, exp_ifrdata);
                end
                fa = rnd_addr();
                ifaddr = fa;
            end
        end
        dreq = 1'b0;
        ifreq = 1'b0;
        tick();
        tick();
        n_checks++;
        if (nd !== 8) begin
            n_errors++; $display("FAIL starve_budget: got %0d dready want 8", nd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, vc;
        bit st, ot;
        logic [31:0] fa;
        slave_wait = 20;
        dreq = 1'b1; dwe = 1'b0; daddr = rnd_addr();
        tick();
        tick();
        n_checks++;
        if (bus_valid !== 1'b1) begin
            n_errors++; $display("FAIL midreset_pre: bus_valid=%b want 1", bus_valid);
        end
        reset = 1'b1;
        dreq = 1'b0;
        tick();
        n_checks++;
        if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_be, ifready, dready, ifrdata, drdata,
             buserr} !== '0) begin
            n_errors++;
            $display("FAIL midreset_values: got %h want 0", {bus_valid, bus_we, bus_addr,
                     bus_wdata, bus_be, ifready, dready, ifrdata, drdata, buserr});
        end
        reset = 1'b0;
        exp_ifrdata = 32'h0;
        exp_drdata = 32'h0;
        tick();
        n_checks++;
        if ({bus_valid, ifready, dready} !== 3'b000) begin
            n_errors++;
            $display("FAIL midreset_idle: got %b want 000", {bus_valid, ifready, dready});
        end
        fa = rnd_addr();
        run_single(1'b0, 1'b0, fa, 32'h0, 4'h0, 0, 0, 32'h0, lat, vc, st, ot);
        exp_ifrdata = mem_rd(fa);
        n_checks++;
        if (lat !== 2 || ifrdata !== exp_ifrdata) begin
            n_errors++;
            $display("FAIL midreset_recover: lat=%0d data=%h want 2/%h", lat, ifrdata,
                     exp_ifrdata);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat, vc;
        bit st, ot;
        logic [31:0] a;
        run_single(1'b0, 1'b0, rnd_addr(), 32'h0, 4'h0, 1000, 0, 32'h0, lat, vc, st, ot);
        n_checks++;
        if (lat !== TbTimeout + 1 || vc !== TbTimeout) begin
            n_errors++;
            $display("FAIL to_fetch_timing: lat=%0d valid=%0d want %0d/%0d", lat, vc,
                     TbTimeout + 1, TbTimeout);
        end
        n_checks++;
        if (ifrdata !== 32'h0000_0013 || buserr !== 1'b1) begin
            n_errors++;
            $display("FAIL to_fetch_abort: if=%h buserr=%b want 00000013/1", ifrdata, buserr);
        end
        run_single(1'b1, 1'b0, rnd_addr(), 32'h0, 4'h0, 1000, 0, 32'h0, lat, vc, st, ot);
        n_checks++;
        if (drdata !== 32'h0 || buserr !== 1'b1 || lat !== TbTimeout + 1) begin
            n_errors++;
            $display("FAIL to_load_abort: d=%h buserr=%b lat=%0d want 0/1/%0d", drdata, buserr,
                     lat, TbTimeout + 1);
        end
        a = rnd_addr();
        run_single(1'b1, 1'b0, a, 32'h0, 4'h0, TbTimeout - 1, 0, 32'h0, lat, vc, st, ot);
        n_checks++;
        if (lat !== TbTimeout + 1 || drdata !== mem_rd(a) || buserr !== 1'b1) begin
            n_errors++;
            $display("FAIL to_boundary: lat=%0d d=%h buserr=%b want %0d/%h/1", lat, drdata,
                     buserr, TbTimeout + 1, mem_rd(a));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_ifrdata = 32'h0;
        exp_drdata = 32'h0;
        n_checks++;
        if (buserr !== 1'b0) begin
            n_errors++; $display("FAIL to_clear: buserr=%b want 0", buserr);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en = 1'b0;
        slave_wait = 0;
        reset = 1'b1;
        ifreq = 1'b0; ifaddr = 32'h0;
        dreq = 1'b0; dwe = 1'b0; daddr = 32'h0; dwdata = 32'h0; dbe = 4'h0;
        test_reset();
        test_single_fetch();
        test_store_waits();
        test_random_access();
        test_simultaneous();
        test_back_to_back();
        test_redirect();
        test_no_starvation();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
